// File: rtl/char_text_buffer_pkg.sv
// char_text_buffer_pkg: grid geometry, message ROM, loader states and glyph generator
// shared by the text buffer and its font ROM.
package char_text_buffer_pkg;
    localparam int TEXT_ROWS = 16;
    localparam int TEXT_COLS = 16;
    localparam int MSG_LEN   = TEXT_COLS;
    localparam int N_MSG     = 4;
    localparam int MSG_ID_W  = $clog2(N_MSG);
    localparam logic [7:0] SPACE_CHAR = 8'h20;
    // Element [MSG_LEN-1] holds the leftmost character of each string.
    typedef logic [MSG_LEN-1:0][7:0] msg_t;
    localparam msg_t MSG_ROM [N_MSG] = '{
        "KONIEC          ",
        "GRACZ 1 WYGRAL  ",
        "GRACZ 2 WYGRAL  ",
        "START           "
    };
    typedef enum logic [1:0] {CLEAR, IDLE, COPY, DONE} txt_state_t;
    // Procedural glyph set: blank for space and control codes.
    function automatic logic [7:0] font_glyph(input logic [6:0] code, input logic [3:0] line);
        return (code <= 7'h20) ? 8'h00 : ({code, 1'b0} ^ {4'h0, line});
    endfunction
endpackage

// File: rtl/char_text_buffer_font_rom.sv
// char_text_buffer_font_rom: 2048 x 8 synchronous glyph ROM,
// address = {character code, glyph line}.
module char_text_buffer_font_rom
    import char_text_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] i_addr,
    output logic [7:0]  o_data
);
    always_ff @(posedge clk)
        o_data <= rst ? 8'h00 : font_glyph(i_addr[10:4], i_addr[3:0]);
endmodule

// File: rtl/char_text_buffer.sv
// char_text_buffer: 16x16 character store with a 2-cycle glyph read path and a
// message loader that clears the grid on reset and copies ROM strings into rows.
module char_text_buffer
    import char_text_buffer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_char_xy,
    input  logic [3:0]          i_char_line,
    output logic [7:0]          o_char_pixels,
    input  logic                i_load,
    input  logic [MSG_ID_W-1:0] i_msg_id,
    input  logic [3:0]          i_row,
    output logic                o_busy,
    output logic                o_done
);
    // Bit 7 of a code never reaches the font, so only 7 bits are stored.
    logic [6:0]          r_ram [256];
    txt_state_t          r_state, w_state_next;
    logic [7:0]          r_clr;
    logic [3:0]          r_col, r_row;
    logic [MSG_ID_W-1:0] r_msg_id;
    logic [6:0]          r_code;
    logic [3:0]          r_line_d1;
    logic                w_we;
    logic [7:0]          w_waddr;
    logic [6:0]          w_wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CLEAR;
            r_clr    <= 8'h00;
            r_col    <= 4'h0;
            r_row    <= 4'h0;
            r_msg_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) r_clr <= r_clr + 8'h01;
            if (r_state == COPY) r_col <= r_col + 4'h1;
            if (r_state == IDLE && i_load) begin
                r_row    <= i_row;
                r_msg_id <= i_msg_id;
                r_col    <= 4'h0;
            end
        end
    end
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   w_state_next = (r_clr == 8'hFF) ? IDLE : CLEAR;
            IDLE:    w_state_next = i_load ? COPY : IDLE;
            COPY:    w_state_next = (r_col == 4'hF) ? DONE : COPY;
            default: w_state_next = IDLE;
        endcase
    end
    // Out-of-range message ids fall back to spaces.
    assign w_we    = (r_state == CLEAR) || (r_state == COPY);
    assign w_waddr = (r_state == CLEAR) ? r_clr : {r_row, r_col};
    assign w_wdata = (r_state == COPY && 32'(r_msg_id) < N_MSG) ? MSG_ROM[r_msg_id][~r_col][6:0]
                                                                : SPACE_CHAR[6:0];
    assign o_busy  = (r_state != IDLE);
    assign o_done  = (r_state == DONE);
    always_ff @(posedge clk)
        if (w_we) r_ram[w_waddr] <= w_wdata;
    // Read-before-write: a same-cycle write to the read address returns the old code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code    <= 7'h00;
            r_line_d1 <= 4'h0;
        end else begin
            r_code    <= r_ram[i_char_xy];
            r_line_d1 <= i_char_line;
        end
    end
    char_text_buffer_font_rom u_font_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr ({r_code, r_line_d1}),
        .o_data (o_char_pixels)
    );
endmodule

// File: tb/tb_char_text_buffer.sv
// tb_char_text_buffer: directed tests of clear sweep, message loads, glyph latency,
// ignored loads and reset during copy.
module tb_char_text_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_xy = 8'h00;
    logic [3:0] char_line = 4'h0;
    logic [7:0] char_pixels;
    logic       load = 1'b0;
    logic [1:0] msg_id = 2'd0;
    logic [3:0] row = 4'h0;
    logic       busy, done;
    int vectors = 0;
    int miscompares = 0;
    localparam logic [7:0] KONIEC [6] = '{8'h4B, 8'h4F, 8'h4E, 8'h49, 8'h45, 8'h43};

    char_text_buffer dut (
        .clk(clk), .rst(rst), .i_char_xy(char_xy), .i_char_line(char_line),
        .o_char_pixels(char_pixels), .i_load(load), .i_msg_id(msg_id), .i_row(row),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] glyph(input logic [7:0] c, input logic [3:0] l);
        logic [7:0] c7;
        c7 = c & 8'h7F;
        if (c7 <= 8'h20) return 8'h00;
        return ((c7 * 2) & 8'hFE) ^ {4'h0, l};
    endfunction

    function automatic logic [7:0] koniec_col(input int col);
        return (col < 6) ? KONIEC[col] : 8'h20;
    endfunction

    task automatic read_pix(input logic [7:0] xy, input logic [3:0] ln, output logic [7:0] pix);
        @(negedge clk);
        char_xy = xy;
        char_line = ln;
        @(negedge clk);
        @(negedge clk);
        pix = char_pixels;
    endtask

    task automatic do_load(input logic [1:0] id, input logic [3:0] r, output bit ok);
        @(negedge clk);
        load = 1'b1; msg_id = id; row = r;
        @(negedge clk);
        load = 1'b0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (done) ok = 1;
            else @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b expected 1", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++;
        if (char_pixels !== 8'h00) begin miscompares++; $display("FAIL reset_pixels: got %h expected 00", char_pixels); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin n++; @(negedge clk); end
        vectors++;
        if (n != 256) begin miscompares++; $display("FAIL clear_busy_cycles: got %0d expected 256", n); end
    endtask

    task automatic test_sweep;
        int bad = 0;
        for (int j = 0; j < 4096 + 2; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                vectors++;
                if (char_pixels !== 8'h00) begin
                    miscompares++;
                    if (bad++ < 8) $display("FAIL sweep_blank idx %0d: got %h expected 00", j - 2, char_pixels);
                end
            end
            if (j < 4096) begin
                char_xy = 8'(j >> 4);
                char_line = 4'(j);
            end
        end
    endtask

    task automatic test_load;
        logic [7:0] pix;
        @(negedge clk);
        load = 1'b1; msg_id = 2'd0; row = 4'h2;
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            vectors++;
            if (busy !== (k <= 17)) begin miscompares++; $display("FAIL load_busy cycle %0d: got %b expected %b", k, busy, k <= 17); end
            vectors++;
            if (done !== (k == 17)) begin miscompares++; $display("FAIL load_done cycle %0d: got %b expected %b", k, done, k == 17); end
            if (k < 18) @(negedge clk);
        end
        read_pix(8'h20, 4'h3, pix);
        vectors++;
        if (pix !== glyph(8'h4B, 4'h3)) begin miscompares++; $display("FAIL load_K: got %h expected %h", pix, glyph(8'h4B, 4'h3)); end
        read_pix(8'h25, 4'h9, pix);
        vectors++;
        if (pix !== glyph(8'h43, 4'h9)) begin miscompares++; $display("FAIL load_C: got %h expected %h", pix, glyph(8'h43, 4'h9)); end
        for (int c = 6; c < 16; c++) begin
            read_pix(8'h20 + 8'(c), 4'(c), pix);
            vectors++;
            if (pix !== 8'h00) begin miscompares++; $display("FAIL load_pad col %0d: got %h expected 00", c, pix); end
        end
    endtask

    task automatic test_latency;
        logic [7:0] exp;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                exp = glyph(koniec_col(j - 2), 4'(15 - (j - 2)));
                vectors++;
                if (char_pixels !== exp) begin miscompares++; $display("FAIL latency col %0d: got %h expected %h", j - 2, char_pixels, exp); end
            end
            if (j < 16) begin
                char_xy = {4'h2, 4'(j)};
                char_line = 4'(15 - j);
            end
        end
    endtask

    task automatic test_load_ignored;
        int dones = 0;
        logic [7:0] pix;
        @(negedge clk);
        load = 1'b1; msg_id = 2'd3; row = 4'h4;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        load = 1'b1; msg_id = 2'd0; row = 4'h5;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 1) begin miscompares++; $display("FAIL ignored_done_count: got %0d expected 1", dones); end
        for (int c = 0; c < 16; c++) begin
            read_pix({4'h5, 4'(c)}, 4'h4, pix);
            vectors++;
            if (pix !== 8'h00) begin miscompares++; $display("FAIL ignored_row5 col %0d: got %h expected 00", c, pix); end
        end
        read_pix(8'h40, 4'h4, pix);
        vectors++;
        if (pix !== glyph(8'h53, 4'h4)) begin miscompares++; $display("FAIL start_S: got %h expected %h", pix, glyph(8'h53, 4'h4)); end
        read_pix(8'h44, 4'h4, pix);
        vectors++;
        if (pix !== glyph(8'h54, 4'h4)) begin miscompares++; $display("FAIL start_T: got %h expected %h", pix, glyph(8'h54, 4'h4)); end
    endtask

    task automatic test_reset_mid_copy;
        int dones = 0;
        int n = 0;
        logic [7:0] pix;
        @(negedge clk);
        load = 1'b1; msg_id = 2'd1; row = 4'h2;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (busy === 1'b1 && n < 400) begin
            if (done === 1'b1) dones++;
            n++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses expected 0", dones); end
        vectors++;
        if (n != 256) begin miscompares++; $display("FAIL abort_clear_cycles: got %0d expected 256", n); end
        for (int c = 0; c < 16; c++) begin
            read_pix({4'h2, 4'(c)}, 4'h7, pix);
            vectors++;
            if (pix !== 8'h00) begin miscompares++; $display("FAIL abort_row2 col %0d: got %h expected 00", c, pix); end
        end
    endtask

    task automatic test_overwrite;
        bit ok;
        logic [7:0] pix;
        logic [7:0] exp;
        do_load(2'd3, 4'hF, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL overwrite_first_done: got 0 expected 1"); end
        do_load(2'd0, 4'hF, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL overwrite_second_done: got 0 expected 1"); end
        for (int c = 0; c < 16; c++) begin
            read_pix({4'hF, 4'(c)}, 4'h7, pix);
            exp = glyph(koniec_col(c), 4'h7);
            vectors++;
            if (pix !== exp) begin miscompares++; $display("FAIL overwrite col %0d: got %h expected %h", c, pix, exp); end
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_load;
        test_latency;
        test_load_ignored;
        test_reset_mid_copy;
        test_overwrite;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
